// File: rtl/imm_dec_stage_if.sv
// Handshake and decoded-immediate bundle between fetch and execute around imm_dec_stage.
// Zero latency (wires only); backpressure is carried by o_ready/i_ready. o_illegal exists only with IMM_ILLEGAL_EN.
interface imm_dec_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_inst;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_inst;
  logic [2:0]       o_src_imm;
  logic [XLEN-1:0]  o_imm;
  logic [CNT_W-1:0] o_stall_cnt;
`ifdef IMM_ILLEGAL_EN
  logic             o_illegal;
`endif

  modport master (
`ifdef IMM_ILLEGAL_EN
    input  o_illegal,
`endif
    output i_flush, i_valid, i_inst, i_ready,
    input  o_ready, o_valid, o_inst, o_src_imm, o_imm, o_stall_cnt
  );

  modport slave (
`ifdef IMM_ILLEGAL_EN
    output o_illegal,
`endif
    input  i_flush, i_valid, i_inst, i_ready,
    output o_ready, o_valid, o_inst, o_src_imm, o_imm, o_stall_cnt
  );
endinterface

// File: rtl/imm_dec_stage.sv
// Decode stage: classifies the opcode, builds the sign-extended immediate and holds it in a 2-entry skid buffer.
// Latency 1 cycle; o_ready is registered and drops only when both entries are occupied. Option: IMM_ILLEGAL_EN.
module imm_dec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  imm_dec_stage_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_U = 3'b101;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [2:0]      src;
    logic [XLEN-1:0] imm;
`ifdef IMM_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  state_t           state, next_state;
  entry_t           main_q, skid_q, dec;
  logic             rdy_q;
  logic [CNT_W-1:0] stall_q;
  logic             out_vld, acc, deq;
  logic             load_main, load_skid, pop_skid;

  // Every format is first built as a 32-bit signed value, then widened to XLEN.
  function automatic entry_t decode(input logic [31:0] inst);
    entry_t     e;
    logic [31:0] imm32;
    e       = '0;
    imm32   = '0;
    e.inst  = inst;
    case (inst[6:0])
      7'b0110011: e.src = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        e.src = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        e.src = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        e.src = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b1101111: begin
        e.src = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        e.src = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      default: begin
        e.src = FMT_R;
`ifdef IMM_ILLEGAL_EN
        e.illegal = 1'b1;
`endif
      end
    endcase
    e.imm = XLEN'(signed'(imm32));
    return e;
  endfunction

  assign dec     = decode(bus.i_inst);
  assign out_vld = (state != EMPTY);
  assign acc     = bus.i_valid & rdy_q;
  assign deq     = out_vld & bus.i_ready;

  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    pop_skid   = 1'b0;
    if (bus.i_flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
        ONE: begin
          if (acc && deq) begin
            load_main = 1'b1;
          end else if (acc) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (deq) begin
            next_state = EMPTY;
          end
        end
        FULL: if (deq) begin
          next_state = ONE;
          pop_skid   = 1'b1;
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state <= next_state;
      rdy_q <= (next_state != FULL);
      if (load_main)     main_q <= dec;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= dec;
      if (out_vld && !bus.i_ready && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.o_valid     = out_vld;
  assign bus.o_ready     = rdy_q;
  assign bus.o_inst      = main_q.inst;
  assign bus.o_src_imm   = main_q.src;
  assign bus.o_imm       = main_q.imm;
  assign bus.o_stall_cnt = stall_q;
`ifdef IMM_ILLEGAL_EN
  assign bus.o_illegal   = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_dec_stage.sv
// Directed bench for imm_dec_stage: reset, formats, skid/stall, flush, streaming, reset mid-stall.
// Inputs change 1 time unit after the rising edge; outputs are checked there too. Honours IMM_ILLEGAL_EN.
module tb_imm_dec_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic i_clk = 1'b0;
  logic i_rstn;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 i_clk = ~i_clk;

  imm_dec_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  imm_dec_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst,
                           input logic [2:0] src, input logic [31:0] imm);
    check({tag, ".valid"}, 64'(bus.o_valid), 64'(1'b1));
    check({tag, ".inst"},  64'(bus.o_inst), 64'(inst));
    check({tag, ".src"},   64'(bus.o_src_imm), 64'(src));
    check({tag, ".imm"},   64'(bus.o_imm), 64'(imm));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, 64'(bus.o_valid), 64'(1'b0));
    check({tag, ".ready"}, 64'(bus.o_ready), 64'(1'b1));
    check({tag, ".inst"},  64'(bus.o_inst), 64'(0));
    check({tag, ".src"},   64'(bus.o_src_imm), 64'(0));
    check({tag, ".imm"},   64'(bus.o_imm), 64'(0));
    check({tag, ".stall"}, 64'(bus.o_stall_cnt), 64'(0));
`ifdef IMM_ILLEGAL_EN
    check({tag, ".illegal"}, 64'(bus.o_illegal), 64'(1'b0));
`endif
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] s_inst [8];
  logic [2:0]  s_src  [8];
  logic [31:0] s_imm  [8];

  initial begin
    // addi, lui(neg), beq -4, auipc, lw -4, add, jal -4, sw -4
    s_inst = '{32'h00A00093, 32'h800000B7, 32'hFE000EE3, 32'h00001097,
               32'hFFC0A103, 32'h00208033, 32'hFFDFF06F, 32'hFE112E23};
    s_src  = '{3'b001, 3'b101, 3'b011, 3'b101, 3'b001, 3'b000, 3'b100, 3'b010};
    s_imm  = '{32'h0000000A, 32'h80000000, 32'hFFFFFFFC, 32'h00001000,
               32'hFFFFFFFC, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC};

    i_rstn      = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_inst  = '0;
    bus.i_ready = 1'b0;
    cyc();
    cyc();
    check_reset("rst");
    i_rstn = 1'b1;

    // addi x1,x0,-1
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'hFFF00093;
    cyc();
    check_out("addi", 32'hFFF00093, 3'b001, 32'hFFFFFFFF);
    check("addi.ready", 64'(bus.o_ready), 64'(1'b1));
`ifdef IMM_ILLEGAL_EN
    check("addi.illegal", 64'(bus.o_illegal), 64'(1'b0));
`endif
    bus.i_valid = 1'b0;
    cyc();
    check("drain.valid", 64'(bus.o_valid), 64'(1'b0));

    // sw then beq into a stalled stage
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'h00112623;
    cyc();
    check("sw.ready", 64'(bus.o_ready), 64'(1'b1));
    bus.i_inst = 32'h00000463;
    cyc();
    check("full.ready", 64'(bus.o_ready), 64'(1'b0));
    check_out("sw", 32'h00112623, 3'b010, 32'd12);
    bus.i_valid = 1'b0;
    cyc();
    cyc();
    check_out("sw_held", 32'h00112623, 3'b010, 32'd12);
    check("stall3", 64'(bus.o_stall_cnt), 64'(3));
    bus.i_ready = 1'b1;
    cyc();
    check_out("beq", 32'h00000463, 3'b011, 32'd8);
    check("beq.ready", 64'(bus.o_ready), 64'(1'b1));
    check("stall_kept", 64'(bus.o_stall_cnt), 64'(3));
    cyc();
    check("beq_drain.valid", 64'(bus.o_valid), 64'(1'b0));

    // jal and lui back-to-back
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'h0080006F;
    cyc();
    check_out("jal", 32'h0080006F, 3'b100, 32'd8);
    bus.i_inst = 32'h123450B7;
    cyc();
    check_out("lui", 32'h123450B7, 3'b101, 32'h12345000);

    // unknown opcodes
    bus.i_inst = 32'h0000007F;
    cyc();
    check_out("unk0", 32'h0000007F, 3'b000, 32'h0);
    bus.i_inst = 32'hFFF0007F;
    cyc();
    check_out("unk1", 32'hFFF0007F, 3'b000, 32'h0);
`ifdef IMM_ILLEGAL_EN
    check("unk1.illegal", 64'(bus.o_illegal), 64'(1'b1));
`endif
    bus.i_valid = 1'b0;
    cyc();

    // fill both entries, then flush with a same-cycle valid instruction
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'h00100093;
    cyc();
    bus.i_inst = 32'h00200113;
    cyc();
    check("pre_flush.ready", 64'(bus.o_ready), 64'(1'b0));
    check("pre_flush.stall", 64'(bus.o_stall_cnt), 64'(4));
    bus.i_flush = 1'b1;
    bus.i_inst  = 32'h00300193;
    cyc();
    check("flush.valid", 64'(bus.o_valid), 64'(1'b0));
    check("flush.ready", 64'(bus.o_ready), 64'(1'b1));
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    cyc();
    check("post_flush.valid", 64'(bus.o_valid), 64'(1'b0));

    // 8 back-to-back instructions, one per cycle
    for (int k = 0; k < 8; k++) begin
      bus.i_valid = 1'b1;
      bus.i_inst  = s_inst[k];
      cyc();
      check_out($sformatf("stream%0d", k), s_inst[k], s_src[k], s_imm[k]);
      check($sformatf("stream%0d.ready", k), 64'(bus.o_ready), 64'(1'b1));
    end
    bus.i_valid = 1'b0;
    cyc();
    check("stream_end.valid", 64'(bus.o_valid), 64'(1'b0));

    // asynchronous reset while stalled
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'hFFF0007F;
    cyc();
    bus.i_inst = 32'h00100093;
    cyc();
    bus.i_valid = 1'b0;
    cyc();
    check("mid.ready", 64'(bus.o_ready), 64'(1'b0));
    i_rstn = 1'b0;
    #1;
    check_reset("rst_mid");
    cyc();
    i_rstn      = 1'b1;
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_inst  = 32'h00A00093;
    cyc();
    check_out("after_rst", 32'h00A00093, 3'b001, 32'h0000000A);
    bus.i_valid = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
